// File: rtl/mips32_pkg.sv
// Shared types and default widths for the MIPS32 unified-memory arbiter.
package mips32_pkg;

   localparam int unsigned ADDR_W_DEF     = 10;
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned STARVE_MAX_DEF = 4;

   // Type of access issued to memory in the previous cycle
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      I_RD = 2'd1,
      D_RD = 2'd2,
      D_WR = 2'd3
   } arb_state_e;

   // Map this cycle's grant onto the access type it issues
   function automatic arb_state_e issue_state(input logic gnt_i,
                                              input logic gnt_d,
                                              input logic we);
      arb_state_e s;
      s = IDLE;
      if (gnt_i)      s = I_RD;
      else if (gnt_d) s = we ? D_WR : D_RD;
      return s;
   endfunction

endpackage

// File: rtl/mips32_arb_starve_cnt.sv
// Fetch starvation counter: counts consecutive denied fetch cycles,
// saturating at STARVE_MAX, cleared whenever fetch is granted.
module mips32_arb_starve_cnt
   import mips32_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk1,
   input  logic rst_n,
   input  logic i_fetch_req,
   input  logic i_fetch_gnt,
   output logic o_starved_c
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] r_cnt;

   // Count denials, saturate at the limit, restart on a fetch grant
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_fetch_gnt) begin
         r_cnt <= '0;
      end else if (i_fetch_req && (r_cnt != CNT_W'(STARVE_MAX))) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_starved_c = (r_cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mips32_mem_arb.sv
// Fetch/data arbiter in front of a single-ported unified memory.
// Data port wins by default; build with MIPS32_ARB_FAIRNESS_EN to let a
// starved fetch win once it has been denied STARVE_MAX cycles in a row.
module mips32_mem_arb
   import mips32_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk1,
   input  logic              rst_n,
   // fetch port
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   // data port
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   // memory port
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   // pipeline stall
   output logic              stall_if
);

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic              w_starved;
   logic              w_i_gnt;
   logic              w_d_gnt;
   logic              w_mem_en;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic              w_i_rvalid;
   logic              w_d_rvalid;
   logic [DATA_W-1:0] r_i_rdata;
   logic [DATA_W-1:0] r_d_rdata;

   if (STARVE_MAX < 1) begin : g_cfg_chk
      $error("mips32_mem_arb: STARVE_MAX must be at least 1");
   end

`ifdef MIPS32_ARB_FAIRNESS_EN
   mips32_arb_starve_cnt #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_cnt (
      .clk1        (clk1),
      .rst_n       (rst_n),
      .i_fetch_req (i_req),
      .i_fetch_gnt (w_i_gnt),
      .o_starved_c (w_starved)
   );
`else
   assign w_starved = 1'b0;
`endif

   // Last-issue state register; reset discards any read in flight
   always_ff @(posedge clk1) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Arbitration, memory command and next state for this cycle
   always_comb begin
      w_i_gnt     = 1'b0;
      w_d_gnt     = 1'b0;
      w_mem_en    = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      w_state_nxt = IDLE;
      if (rst_n) begin
         if (i_req && (!d_req || w_starved)) begin
            w_i_gnt    = 1'b1;
            w_mem_en   = 1'b1;
            w_mem_addr = i_addr;
         end else if (d_req) begin
            w_d_gnt     = 1'b1;
            w_mem_en    = 1'b1;
            w_mem_we    = d_we;
            w_mem_addr  = d_addr;
            w_mem_wdata = d_wdata;
         end
         w_state_nxt = issue_state(w_i_gnt, w_d_gnt, d_we);
      end
   end

   // Read data is returned in the cycle after issue; masked during reset
   assign w_i_rvalid = rst_n && (r_state == I_RD);
   assign w_d_rvalid = rst_n && (r_state == D_RD);

   // Keep the last delivered word of each port for the idle cycles
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         if (w_i_rvalid) r_i_rdata <= mem_rdata;
         if (w_d_rvalid) r_d_rdata <= mem_rdata;
      end
   end

   assign i_gnt     = w_i_gnt;
   assign d_gnt     = w_d_gnt;
   assign mem_en    = w_mem_en;
   assign mem_we    = w_mem_we;
   assign mem_addr  = w_mem_addr;
   assign mem_wdata = w_mem_wdata;
   assign stall_if  = rst_n && i_req && !w_i_gnt;
   assign i_rvalid  = w_i_rvalid;
   assign d_rvalid  = w_d_rvalid;
   assign i_rdata   = w_i_rvalid ? mem_rdata : r_i_rdata;
   assign d_rdata   = w_d_rvalid ? mem_rdata : r_d_rdata;

endmodule
